// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 SPI arbiter.
// Holds the FSM state encoding and the RX gain command helper.
package ad9866_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    XFER,
    RESP,
    GAP
  } state_e;

  localparam logic [7:0] AD9866_GAIN_ADDR   = 8'h0a;
  localparam logic [1:0] AD9866_GAIN_PREFIX = 2'b01;

  typedef logic [15:0] spi_cmd_t;

  function automatic spi_cmd_t gain_cmd(input logic [5:0] g);
    return {AD9866_GAIN_ADDR, AD9866_GAIN_PREFIX, g};
  endfunction

endpackage

// File: rtl/ad9866_spi_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches req upward from ptr with wrap; returns one-hot grant.
module rr_arbiter
  import ad9866_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  localparam logic [PW:0] NL = (PW + 1)'(N);

  // first requesting slot at or after ptr, wrapping
  always_comb begin : pick
    logic [PW:0] sum;
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= NL) sum = sum - NL;
      if (!valid && req[sum[PW-1:0]]) begin
        grant[sum[PW-1:0]] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad9866_spi_arbiter.sv
// Shares the AD9866 SPI engine between NREQ command requesters
// and a coalescing RX-gain updater, one transaction at a time.
module ad9866_spi_arbiter
  import ad9866_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 8,
  parameter int XFER_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_cmd,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  input  logic                 gain_update,
  input  logic [5:0]           gain,
  output logic                 gain_pending,
  output logic                 spi_start,
  output logic [15:0]          spi_cmd,
  input  logic                 spi_busy,
  input  logic [7:0]           spi_rdata,
  output logic                 err_sticky
);

  localparam int N  = NREQ + 1;
  localparam int PW = $clog2(N);

  localparam int CMAX =
    (ACK_TIMEOUT > XFER_TIMEOUT) ?
      ((ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES) :
      ((XFER_TIMEOUT > GAP_CYCLES) ? XFER_TIMEOUT : GAP_CYCLES);
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST = CW'(XFER_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] GAIN_SLOT = PW'(NREQ);

  state_e          state_q, state_d;
  logic [PW-1:0]   slot_q, slot_d;
  spi_cmd_t        cmd_q, cmd_d;
  logic            start_q, start_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic [5:0]      gain_reg_q, gain_reg_d;
  logic            gpend_q, gpend_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N-1:0]    req_vec;
  logic [N-1:0]    grant;
  logic            gvalid;
  logic [PW-1:0]   gidx;
  spi_cmd_t        sel_cmd;
  logic            accept;

  assign req_vec = {gpend_q, req_valid};
  assign accept  = (state_q == IDLE) && gvalid;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_rr (
    .req   (req_vec),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .valid (gvalid)
  );

  // one-hot grant to slot index and the matching command word
  always_comb begin
    gidx    = '0;
    sel_cmd = gain_cmd(gain_reg_q);
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_cmd = req_cmd[16*i +: 16];
    end
  end

  // gain capture; a same-cycle update wins over the grant clear
  always_comb begin
    gpend_d    = gpend_q;
    gain_reg_d = gain_reg_q;
    if (accept && grant[NREQ]) gpend_d = 1'b0;
    if (gain_update) begin
      gpend_d    = 1'b1;
      gain_reg_d = gain;
    end
  end

  // transaction FSM: grant, wait for busy, wait for idle, respond, gap
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cmd_d    = cmd_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (gvalid) begin
          slot_d   = gidx;
          cmd_d    = sel_cmd;
          start_d  = 1'b1;
          cnt_d    = '0;
          err_d    = 1'b0;
          rdata_d  = 8'h00;
          rr_ptr_d = (gidx == GAIN_SLOT) ? '0 : gidx + 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (spi_busy) begin
          cnt_d   = '0;
          state_d = XFER;
        end else if (cnt_q == ACK_LAST) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          rdata_d  = 8'h00;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      XFER: begin
        if (!spi_busy) begin
          rdata_d = spi_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == XFER_LAST) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          rdata_d  = 8'h00;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      cmd_q      <= '0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      gain_reg_q <= '0;
      gpend_q    <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cmd_q      <= cmd_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      gain_reg_q <= gain_reg_d;
      gpend_q    <= gpend_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // response decode; gain slot never gets a response pulse
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (slot_q == PW'(i));
    end
  end

  assign req_ready    = accept ? grant[NREQ-1:0] : '0;
  assign rsp_data     = (state_q == RESP) ? rdata_q : 8'h00;
  assign rsp_err      = (state_q == RESP) && err_q;
  assign gain_pending = gpend_q;
  assign spi_start    = start_q;
  assign spi_cmd      = cmd_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_ad9866_spi_arbiter.sv
// Bench for ad9866_spi_arbiter: transaction-level timing model
// plus directed scenarios with literal expectations.
module tb_ad9866_spi_arbiter;

  localparam int NREQ = 2;
  localparam int N    = NREQ + 1;
  localparam int GAPC = 4;
  localparam int ACKT = 8;
  localparam int XFRT = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*16-1:0] req_cmd = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              gain_update = 1'b0;
  logic [5:0]        gain = '0;
  logic              gain_pending;
  logic              spi_start;
  logic [15:0]       spi_cmd;
  logic              spi_busy = 1'b0;
  logic [7:0]        spi_rdata = 8'h00;
  logic              err_sticky;

  ad9866_spi_arbiter #(
    .NREQ(NREQ), .GAP_CYCLES(GAPC),
    .ACK_TIMEOUT(ACKT), .XFER_TIMEOUT(XFRT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gain_update(gain_update), .gain(gain),
    .gain_pending(gain_pending),
    .spi_start(spi_start), .spi_cmd(spi_cmd),
    .spi_busy(spi_busy), .spi_rdata(spi_rdata),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // engine: busy for eng_len cycles after each start (0 = never)
  int eng_len = 3;
  int rem = 0;
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) rem = 0;
      else if (spi_start) rem = eng_len;
      #1;
      if (rem > 0) begin
        spi_busy = 1'b1;
        rem--;
      end else begin
        spi_busy = 1'b0;
      end
    end
  end

  // model state
  int          cyc = 0;
  bit          armed = 0;
  bit          in_txn;
  int          next_free, exp_start, rsp_cyc;
  int          m_slot, m_ptr, lat;
  logic [15:0] m_cmd;
  bit          m_gpend, m_err, txn_err;
  logic [5:0]  m_gval;
  logic [7:0]  txn_data;
  bit          prev_busy;
  int          fall_cyc;
  int          glog[$];
  logic [15:0] clog[$];
  logic [7:0]  last_rsp_data;
  logic        last_rsp_err;

  // compare process: model decides, DUT is checked each cycle
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        armed     = 1;
        in_txn    = 0;
        next_free = cyc + 1;
        exp_start = -1;
        rsp_cyc   = -1;
        m_cmd     = '0;
        m_gpend   = 0;
        m_gval    = '0;
        m_ptr     = 0;
        m_err     = 0;
        prev_busy = 0;
        fall_cyc  = 0;
      end else if (armed) begin
        int g;
        logic [2:0] reqv;
        logic [NREQ-1:0] exp_rdy, exp_rsp;
        if (prev_busy && !spi_busy) fall_cyc = cyc;
        prev_busy = spi_busy;
        if (cyc == exp_start) begin
          if (eng_len == 0) begin
            rsp_cyc = cyc + ACKT;
            txn_err = 1;
            txn_data = 8'h00;
          end else if (eng_len > XFRT) begin
            rsp_cyc = cyc + 2 + XFRT;
            txn_err = 1;
            txn_data = 8'h00;
          end else begin
            rsp_cyc = cyc + eng_len + 2;
            txn_err = 0;
            txn_data = spi_rdata;
          end
          lat = rsp_cyc - cyc;
          if (fall_cyc > 0)
            chk("start_gap", 32'(cyc - fall_cyc > GAPC), 1);
        end
        if (cyc == rsp_cyc && txn_err) m_err = 1;
        g = -1;
        reqv = {m_gpend, req_valid};
        if (!in_txn && cyc >= next_free) begin
          for (int k = 0; k < N; k++) begin
            int s;
            s = (m_ptr + k) % N;
            if (g < 0 && ((reqv >> s) & 3'b001) != 0) g = s;
          end
        end
        exp_rdy = (g >= 0 && g < NREQ) ? (2'b01 << g) : 2'b00;
        exp_rsp = (cyc == rsp_cyc && m_slot < NREQ) ?
                  (2'b01 << m_slot) : 2'b00;
        chk("req_ready", req_ready, exp_rdy);
        chk("spi_start", spi_start, cyc == exp_start);
        chk("spi_cmd", spi_cmd, m_cmd);
        chk("rsp_valid", rsp_valid, exp_rsp);
        if (exp_rsp != 0) begin
          chk("rsp_data", rsp_data, txn_data);
          chk("rsp_err", rsp_err, txn_err);
        end
        if (rsp_valid != 0) begin
          last_rsp_data = rsp_data;
          last_rsp_err  = rsp_err;
        end
        chk("gain_pending", gain_pending, m_gpend);
        chk("err_sticky", err_sticky, m_err);
        if (cyc == rsp_cyc) begin
          in_txn    = 0;
          next_free = cyc + 1 + GAPC;
        end
        if (g >= 0) begin
          in_txn    = 1;
          m_slot    = g;
          exp_start = cyc + 1;
          if (g == NREQ) m_cmd = {8'h0a, 2'b01, m_gval};
          else if (g == 1) m_cmd = req_cmd[31:16];
          else m_cmd = req_cmd[15:0];
          m_ptr = (g + 1) % N;
          glog.push_back(g);
          clog.push_back(m_cmd);
          if (g == NREQ) m_gpend = 0;
        end
        if (gain_update) begin
          m_gpend = 1;
          m_gval  = gain;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit s, input logic [15:0] c,
                        output int waited);
    bit got;
    got = 0;
    waited = 0;
    req_valid[s] = 1'b1;
    if (s) req_cmd[31:16] = c;
    else req_cmd[15:0] = c;
    while (!got && waited < 300) begin
      @(negedge clk);
      if (req_ready[s]) got = 1;
      else waited++;
    end
    if (!got) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
  endtask

  task automatic pulse_gain(input logic [5:0] v);
    gain = v;
    gain_update = 1'b1;
    tick(1);
    gain_update = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
  endtask

  function automatic int count_gain(input int base);
    int n;
    n = 0;
    for (int i = base; i < glog.size(); i++)
      if (glog[i] == NREQ) n++;
    return n;
  endfunction

  initial begin
    int w, base, n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 0, 1};

    tick(3);
    reset_n = 1'b1;
    chk("reset_cmd", spi_cmd, 16'h0000);
    chk("reset_sticky", err_sticky, 0);
    chk("reset_gpend", gain_pending, 0);
    tick(2);

    // single generic request
    eng_len = 34;
    spi_rdata = 8'h01;
    do_req(0, 16'h8D00, w);
    chk("t1_wait", w, 0);
    tick(50);
    chk("t1_rsp_data", last_rsp_data, 8'h01);
    chk("t1_latency", lat, 36);
    chk("t1_cmd_log", clog[0], 16'h8D00);

    // reset in the middle of a transfer
    eng_len = 40;
    do_req(0, 16'h0102, w);
    tick(10);
    pulse_gain(6'h07);
    tick(2);
    do_reset();
    chk("rst_start", spi_start, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_gpend", gain_pending, 0);
    chk("rst_cmd", spi_cmd, 16'h0000);
    eng_len = 2;
    do_req(1, 16'h0304, w);
    chk("rst_accept_wait", w, 0);
    tick(20);

    // round robin with gain pending
    do_reset();
    tick(2);
    eng_len = 3;
    base = glog.size();
    req_cmd = {16'h2222, 16'h1111};
    req_valid = 2'b11;
    pulse_gain(6'h15);
    n = 0;
    while (glog.size() < base + 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("rr_count", 32'(glog.size() >= base + 5), 1);
    if (glog.size() >= base + 5) begin
      for (int k = 0; k < 5; k++)
        chk("rr_order", glog[base+k], exp_order[k]);
      chk("rr_gain_cmd", clog[base+2], 16'h0A55);
    end
    tick(20);

    // gain coalescing during a transfer
    eng_len = 20;
    base = glog.size();
    do_req(0, 16'h0555, w);
    tick(3);
    pulse_gain(6'h05);
    tick(2);
    pulse_gain(6'h12);
    tick(2);
    pulse_gain(6'h3F);
    tick(60);
    chk("coal_count", count_gain(base), 1);
    if (glog.size() == base + 2)
      chk("coal_cmd", clog[base+1], 16'h0A7F);
    else
      chk("coal_log", glog.size(), base + 2);

    // ack timeout, then the next request is served
    eng_len = 0;
    do_req(1, 16'h1234, w);
    tick(12);
    chk("ackto_err", last_rsp_err, 1);
    chk("ackto_data", last_rsp_data, 8'h00);
    chk("ackto_sticky", err_sticky, 1);
    chk("ackto_lat", lat, 8);
    eng_len = 5;
    spi_rdata = 8'h5A;
    do_req(0, 16'h4321, w);
    tick(15);
    chk("after_to_err", last_rsp_err, 0);
    chk("after_to_data", last_rsp_data, 8'h5A);

    // grant and new gain_update in the same cycle
    eng_len = 3;
    base = glog.size();
    gain = 6'h0A;
    gain_update = 1'b1;
    tick(1);
    gain = 6'h21;
    tick(1);
    gain_update = 1'b0;
    tick(40);
    chk("sim_count", count_gain(base), 2);
    if (glog.size() == base + 2) begin
      chk("sim_cmd0", clog[base], 16'h0A4A);
      chk("sim_cmd1", clog[base+1], 16'h0A61);
    end

    // transfer timeout
    eng_len = 70;
    spi_rdata = 8'hEE;
    do_req(0, 16'h7777, w);
    tick(90);
    chk("xferto_err", last_rsp_err, 1);
    chk("xferto_data", last_rsp_data, 8'h00);
    chk("xferto_lat", lat, 66);
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
